// File: rtl/ws2812_pkg.sv
// Shared types and timing helper for the WS2812 frame sequencer.
package ws2812_pkg;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_LOAD,
      ST_SEND,
      ST_LATCH
   } frame_state_e;

   // Latch (line-low) gap in clocks for a given clock rate and gap length in µs.
   function automatic int calc_reset_cycles(input int clk_hz, input int reset_us);
      return (clk_hz / 1_000_000) * reset_us;
   endfunction

endpackage

// File: rtl/ws2812_pixel_ram.sv
// NUM_LEDS x 24 simple dual-port pixel store: one write port, one
// synchronous read port with read-first behaviour on address collision.
module ws2812_pixel_ram
   import ws2812_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = 3
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  rgb_t          wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output rgb_t          rdata
);

   rgb_t mem [DEPTH];

   // Both ports in one block: a colliding read sees the pre-write word.
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata <= mem[raddr];
   end

endmodule

// File: rtl/ws2812_frame_ctrl.sv
// WS2812 frame sequencer: streams the pixel store to the serializer, then
// holds the latch gap. Optional idle auto-refresh under WS2812_AUTO_REFRESH_EN.
module ws2812_frame_ctrl
   import ws2812_pkg::*;
#(
   parameter int NUM_LEDS       = 8,
   parameter int CLK_HZ         = 100_000_000,
   parameter int RESET_US       = 80,
   parameter int REFRESH_CYCLES = 1_000_000,
   localparam int AW            = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [23:0]   wr_rgb,
   input  logic          start,
   output logic          busy,
   output logic          frame_done,
   output logic          px_valid,
   output logic [23:0]   px_rgb,
   input  logic          px_ready
);

   localparam int RESET_CYCLES = calc_reset_cycles(CLK_HZ, RESET_US);
   localparam int LW           = $clog2(RESET_CYCLES + 1);
   localparam logic [AW-1:0] LAST_IDX = AW'(NUM_LEDS - 1);
   localparam logic [AW:0]   NUM_W    = (AW+1)'(NUM_LEDS);
   localparam logic [LW-1:0] LAST_CNT = LW'(RESET_CYCLES - 1);
   localparam logic [LW-1:0] PRE_CNT  = LW'((RESET_CYCLES >= 2) ? RESET_CYCLES - 2 : 0);

   if (NUM_LEDS < 1 || RESET_CYCLES < 1 || REFRESH_CYCLES < 1) begin : g_param_check
      $error("ws2812_frame_ctrl: illegal parameter values");
   end

   frame_state_e  state;
   logic [AW-1:0] idx;
   logic          pending;
   logic [LW-1:0] latch_cnt;
   logic          launch;
   logic          wr_ok;
   rgb_t          rd_px;

   assign wr_ok = wr_en && ({1'b0, wr_addr} < NUM_W);

`ifdef WS2812_AUTO_REFRESH_EN
   localparam int RW = $clog2(REFRESH_CYCLES + 1);
   logic [RW-1:0] refresh_cnt;

   // Counts consecutive IDLE cycles; the final count doubles as a start.
   always_ff @(posedge clk) begin
      if (rst || state != ST_IDLE) refresh_cnt <= '0;
      else                         refresh_cnt <= refresh_cnt + 1'b1;
   end

   assign launch = start || pending || (refresh_cnt == RW'(REFRESH_CYCLES - 1));
`else
   assign launch = start || pending;
`endif

   ws2812_pixel_ram #(
      .DEPTH (NUM_LEDS),
      .AW    (AW)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata (rgb_t'(wr_rgb)),
      .re    (state == ST_LOAD),
      .raddr (idx),
      .rdata (rd_px)
   );

   // RAM output only moves on a LOAD read, so it holds steady under backpressure.
   assign px_rgb = px_valid ? rd_px : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         idx        <= '0;
         pending    <= 1'b0;
         latch_cnt  <= '0;
         busy       <= 1'b0;
         frame_done <= 1'b0;
         px_valid   <= 1'b0;
      end else begin
         if (start && state != ST_IDLE) pending <= 1'b1;
         unique case (state)
            ST_IDLE: begin
               idx     <= '0;
               pending <= 1'b0;
               if (launch) begin
                  state <= ST_LOAD;
                  busy  <= 1'b1;
               end
            end
            ST_LOAD: begin
               state    <= ST_SEND;
               px_valid <= 1'b1;
            end
            ST_SEND: begin
               if (px_ready) begin
                  px_valid <= 1'b0;
                  if (idx == LAST_IDX) begin
                     state      <= ST_LATCH;
                     latch_cnt  <= '0;
                     frame_done <= (RESET_CYCLES == 1);
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= ST_LOAD;
                  end
               end
            end
            ST_LATCH: begin
               // frame_done is raised one count early so it lands on the last gap cycle.
               if (latch_cnt == LAST_CNT) begin
                  state      <= ST_IDLE;
                  frame_done <= 1'b0;
                  busy       <= 1'b0;
               end else begin
                  latch_cnt  <= latch_cnt + 1'b1;
                  frame_done <= (latch_cnt == PRE_CNT);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
